// File: rtl/rf_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard.
// Holds the default register count, select width, counter width/ceiling
// and the RUN/DRAIN state encoding used by rf_scoreboard.
package rf_scoreboard_pkg;

  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_SEL_W = 3;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned CNT_MAX   = (2 ** CNT_W) - 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_e;

endpackage : rf_scoreboard_pkg

// File: rtl/sb_counter.sv
// Per-register pending-write counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc, dec  - count up (issue) / count down (retire); both together hold
//   clr       - clear to zero, overrides inc/dec
//   cnt       - current count
//   zero, max - current count is zero / saturated at all-ones
//   zero_nxt  - count will be zero after this edge
module sb_counter
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = rf_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max,
  output logic             zero_nxt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !max) begin
      cnt_d = cnt_q + ONE;
    end else if (dec && !inc && !zero) begin
      // A decrement of an empty counter is ignored (never wraps).
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign zero     = (cnt_q == '0);
  assign max      = (cnt_q == '1);
  assign zero_nxt = (cnt_d == '0);

endmodule : sb_counter

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: tracks pending writes per register and stalls
// decode on RAW hazards, counter saturation, or while draining.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   issue_valid/_wr_en/_wr_reg   - instruction presented by decode
//   rd1_used/rd1_reg, rd2_*      - source operands of that instruction
//   retire_valid, retire_reg     - write-back commit
//   flush                        - discard all in-flight writes
//   drain_req                    - request to empty the pipeline (pulse)
//   stall                        - combinational hold for decode
//   busy_mask                    - bit i set while register i has pending writes
//   drain_done                   - one-cycle pulse when a drain completes
//   err                          - one-cycle pulse on retire to an idle register
// Optional feature macro: RF_SCOREBOARD_RETIRE_BYPASS_EN
//   When defined, a source hazard on a register whose single pending write
//   retires this cycle is suppressed (write-back value is forwarded).
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = rf_scoreboard_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = rf_scoreboard_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic                        issue_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] issue_wr_reg,
  input  logic                        rd1_used,
  input  logic [$clog2(NUM_REGS)-1:0] rd1_reg,
  input  logic                        rd2_used,
  input  logic [$clog2(NUM_REGS)-1:0] rd2_reg,
  input  logic                        retire_valid,
  input  logic [$clog2(NUM_REGS)-1:0] retire_reg,
  input  logic                        flush,
  input  logic                        drain_req,
  output logic                        stall,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic                        drain_done,
  output logic                        err
);

  localparam int unsigned SEL_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

`ifdef RF_SCOREBOARD_RETIRE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  sb_state_e state_q, state_d;
  logic      drain_done_q, drain_done_d;
  logic      err_q, err_d;

  logic [NUM_REGS-1:0] inc_v, dec_v, zero_v, max_v, zero_nxt_v;
  logic [CNT_W-1:0]    cnt_v [NUM_REGS];

  logic byp1, byp2, haz1, haz2, waw_full, accept;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc_v[g]),
      .dec      (dec_v[g]),
      .clr      (flush),
      .cnt      (cnt_v[g]),
      .zero     (zero_v[g]),
      .max      (max_v[g]),
      .zero_nxt (zero_nxt_v[g])
    );
  end

  // Hazard and stall evaluation.
  always_comb begin
    byp1 = BYPASS_EN && retire_valid && (retire_reg == rd1_reg) &&
           (cnt_v[rd1_reg] == ONE);
    byp2 = BYPASS_EN && retire_valid && (retire_reg == rd2_reg) &&
           (cnt_v[rd2_reg] == ONE);
    haz1     = rd1_used && !zero_v[rd1_reg] && !byp1;
    haz2     = rd2_used && !zero_v[rd2_reg] && !byp2;
    waw_full = issue_wr_en && max_v[issue_wr_reg];
    stall    = issue_valid &&
               ((state_q == ST_DRAIN) || haz1 || haz2 || waw_full);
    accept   = issue_valid && !stall;
  end

  // Per-register increment/decrement strobes.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_v[i] = accept && issue_wr_en && (issue_wr_reg == SEL_W'(i));
      dec_v[i] = retire_valid && (retire_reg == SEL_W'(i));
    end
  end

  // Drain FSM and status pulses.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    err_d        = retire_valid && !flush && zero_v[retire_reg];
    unique case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Completion uses post-update counter state so the final retire
        // (or a flush) ends the drain on the same edge.
        if (flush || (&zero_nxt_v)) begin
          state_d      = ST_RUN;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  assign busy_mask  = ~zero_v;
  assign drain_done = drain_done_q;
  assign err        = err_q;

endmodule : rf_scoreboard
